// File: rtl/iter_shifter.sv
// Multi-cycle shifter: num << shamt built from repeated 5-bit (sl5) and 1-bit steps.
// Optional SHIFT_SRL_EN adds a dir port selecting a logical right shift.

module sl5 #(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] a,
    output logic [n-1:0] y
);
    assign y = a << 5;
endmodule

module iter_shifter #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] num,
    input  logic [4:0]   shamt,
`ifdef SHIFT_SRL_EN
    input  logic         dir,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [n-1:0] r_acc, w_acc_nxt;
    logic [4:0]   r_cnt, w_cnt_nxt;
    logic [n-1:0] r_result;
    logic         r_ready, r_busy, r_done;
    logic [n-1:0] w_sl5, w_step5, w_step1;

    sl5 #(.n(n)) u_sl5 (
        .a (r_acc),
        .y (w_sl5)
    );

`ifdef SHIFT_SRL_EN
    logic r_dir_q, w_dir_nxt;

    assign w_step5 = r_dir_q ? (r_acc >> 5) : w_sl5;
    assign w_step1 = r_dir_q ? (r_acc >> 1) : (r_acc << 1);
`else
    assign w_step5 = w_sl5;
    assign w_step1 = r_acc << 1;
`endif

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
`ifdef SHIFT_SRL_EN
        w_dir_nxt   = r_dir_q;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_acc_nxt   = num;
                    w_cnt_nxt   = shamt;
`ifdef SHIFT_SRL_EN
                    w_dir_nxt   = dir;
`endif
                    w_state_nxt = (shamt != 5'd0) ? ST_SHIFT : ST_DONE;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt >= 5'd5) begin
                    w_acc_nxt = w_step5;
                    w_cnt_nxt = r_cnt - 5'd5;
                end else begin
                    w_acc_nxt = w_step1;
                    w_cnt_nxt = r_cnt - 5'd1;
                end
                if (w_cnt_nxt == 5'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status flags and result are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_cnt    <= 5'd0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SHIFT_SRL_EN
            r_dir_q  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt != ST_SHIFT);
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) begin
                r_result <= w_acc_nxt;
            end
`ifdef SHIFT_SRL_EN
            r_dir_q <= w_dir_nxt;
`endif
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
endmodule
